// File: rtl/pcra_pkg.sv
// Shared definitions for the program-counter / return-address block:
// default widths, reset vector and the memory-bus arbitration states.
package pcra_pkg;

    localparam int          PCRA_ADDR_W       = 16;
    localparam logic [15:0] PCRA_RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DRAIN   = 2'd1,
        GRANTED = 2'd2
    } bus_state_e;

endpackage

// File: rtl/pcra_counter.sv
// One PCRA register: load beats increment beats hold. wrap_o flags an
// increment that actually takes effect this cycle while the register is all-ones.
module pcra_counter
    import pcra_pkg::*;
#(
    parameter int                ADDR_W  = PCRA_ADDR_W,
    parameter logic [ADDR_W-1:0] RST_VAL = {ADDR_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_data_i,
    output logic [ADDR_W-1:0] value_o,
    output logic              wrap_o
);

    logic [ADDR_W-1:0] value_q;
    logic [ADDR_W-1:0] value_d;

    // Next-value selection
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_data_i;
        end else if (inc_i) begin
            value_d = value_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            value_d = value_q;
        end
    end

    // Register state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign wrap_o  = inc_i & ~load_i & (&value_q);

endmodule

// File: rtl/program_counter_ra.sv
// PC/RA register pair with role flip and fetch-bus drain/grant arbitration.
// Optional sticky PC wrap detection is enabled by defining PCRA_WRAP_DETECT_EN.
module program_counter_ra
    import pcra_pkg::*;
#(
    parameter int                ADDR_W       = PCRA_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = PCRA_RESET_VECTOR
) (
    input  logic              ClockIn,
    input  logic              ResetIn_n,
    input  logic              IncPCRA0,
    input  logic              IncPCRA1,
    input  logic              FlipPCRA,
    input  logic              LoadPC,
    input  logic              LoadRA,
    input  logic [ADDR_W-1:0] LoadData,
    input  logic              BusRequest,
    output logic              BusGrant,
    output logic [ADDR_W-1:0] FetchAddr,
    output logic              FetchValid,
    output logic [ADDR_W-1:0] RAOut,
    output logic              Flags_5_PCRA_Flip,
    output logic              PCWrap
);

    bus_state_e        state_q;
    logic              fetch_valid_q;
    logic              bus_grant_q;
    logic              flip_q;
    logic              inc_en_s;
    logic              load0_s;
    logic              load1_s;
    logic [ADDR_W-1:0] reg0_s;
    logic [ADDR_W-1:0] reg1_s;
    logic              wrap0_s;
    logic              wrap1_s;

    assign inc_en_s = (state_q == FETCH);
    // Loads resolve through the mapping in force before any same-cycle flip.
    assign load0_s  = flip_q ? LoadRA : LoadPC;
    assign load1_s  = flip_q ? LoadPC : LoadRA;

    pcra_counter #(
        .ADDR_W  (ADDR_W),
        .RST_VAL (RESET_VECTOR)
    ) u_reg0 (
        .clk_i       (ClockIn),
        .rst_ni      (ResetIn_n),
        .load_i      (load0_s),
        .inc_i       (IncPCRA0 & inc_en_s),
        .load_data_i (LoadData),
        .value_o     (reg0_s),
        .wrap_o      (wrap0_s)
    );

    pcra_counter #(
        .ADDR_W  (ADDR_W),
        .RST_VAL ({ADDR_W{1'b0}})
    ) u_reg1 (
        .clk_i       (ClockIn),
        .rst_ni      (ResetIn_n),
        .load_i      (load1_s),
        .inc_i       (IncPCRA1 & inc_en_s),
        .load_data_i (LoadData),
        .value_o     (reg1_s),
        .wrap_o      (wrap1_s)
    );

    // Role bit toggles on each flip strobe
    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            flip_q <= 1'b0;
        end else begin
            flip_q <= flip_q ^ FlipPCRA;
        end
    end

    // Bus arbitration FSM with registered FetchValid/BusGrant
    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            state_q       <= FETCH;
            fetch_valid_q <= 1'b1;
            bus_grant_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (BusRequest) begin
                        state_q       <= DRAIN;
                        fetch_valid_q <= 1'b0;
                        bus_grant_q   <= 1'b0;
                    end else begin
                        state_q       <= FETCH;
                        fetch_valid_q <= 1'b1;
                        bus_grant_q   <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (BusRequest) begin
                        state_q       <= GRANTED;
                        fetch_valid_q <= 1'b0;
                        bus_grant_q   <= 1'b1;
                    end else begin
                        state_q       <= FETCH;
                        fetch_valid_q <= 1'b1;
                        bus_grant_q   <= 1'b0;
                    end
                end
                GRANTED: begin
                    if (!BusRequest) begin
                        state_q       <= FETCH;
                        fetch_valid_q <= 1'b1;
                        bus_grant_q   <= 1'b0;
                    end else begin
                        state_q       <= GRANTED;
                        fetch_valid_q <= 1'b0;
                        bus_grant_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= FETCH;
                    fetch_valid_q <= 1'b1;
                    bus_grant_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PCRA_WRAP_DETECT_EN
    logic pc_wrap_s;
    logic pc_wrap_q;

    assign pc_wrap_s = flip_q ? wrap1_s : wrap0_s;

    // Sticky wrap flag; a PC load clears it
    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            pc_wrap_q <= 1'b0;
        end else if (LoadPC) begin
            pc_wrap_q <= 1'b0;
        end else if (pc_wrap_s) begin
            pc_wrap_q <= 1'b1;
        end else begin
            pc_wrap_q <= pc_wrap_q;
        end
    end

    assign PCWrap = pc_wrap_q;
`else
    logic unused_wrap_s;

    assign unused_wrap_s = wrap0_s | wrap1_s;
    assign PCWrap        = 1'b0;
`endif

    assign FetchAddr         = flip_q ? reg1_s : reg0_s;
    assign RAOut             = flip_q ? reg0_s : reg1_s;
    assign FetchValid        = fetch_valid_q;
    assign BusGrant          = bus_grant_q;
    assign Flags_5_PCRA_Flip = flip_q;

endmodule

// File: tb/tb_program_counter_ra.sv
// Directed self-checking bench for program_counter_ra (default parameters).
module tb_program_counter_ra;

    logic        clk;
    logic        rst_n;
    logic        inc0;
    logic        inc1;
    logic        flip;
    logic        load_pc;
    logic        load_ra;
    logic [15:0] load_data;
    logic        bus_req;
    logic        bus_grant;
    logic [15:0] fetch_addr;
    logic        fetch_valid;
    logic [15:0] ra_out;
    logic        flag_flip;
    logic        pc_wrap;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_wrap;

    program_counter_ra dut (
        .ClockIn           (clk),
        .ResetIn_n         (rst_n),
        .IncPCRA0          (inc0),
        .IncPCRA1          (inc1),
        .FlipPCRA          (flip),
        .LoadPC            (load_pc),
        .LoadRA            (load_ra),
        .LoadData          (load_data),
        .BusRequest        (bus_req),
        .BusGrant          (bus_grant),
        .FetchAddr         (fetch_addr),
        .FetchValid        (fetch_valid),
        .RAOut             (ra_out),
        .Flags_5_PCRA_Flip (flag_flip),
        .PCWrap            (pc_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef PCRA_WRAP_DETECT_EN
        exp_wrap = 1'b1;
`else
        exp_wrap = 1'b0;
`endif
        rst_n = 1'b0; inc0 = 1'b0; inc1 = 1'b0; flip = 1'b0;
        load_pc = 1'b0; load_ra = 1'b0; load_data = 16'h0000; bus_req = 1'b0;
        step(); step();
        check("rst_fetch_addr", fetch_addr, 16'h0000);
        check("rst_ra", ra_out, 16'h0000);
        check("rst_fetch_valid", {15'd0, fetch_valid}, 16'h0001);
        check("rst_grant", {15'd0, bus_grant}, 16'h0000);
        check("rst_flip", {15'd0, flag_flip}, 16'h0000);
        check("rst_wrap", {15'd0, pc_wrap}, 16'h0000);
        rst_n = 1'b1;
        step();

        // Three increments of reg0
        inc0 = 1'b1;
        step(); check("inc_1", fetch_addr, 16'h0001);
        step(); check("inc_2", fetch_addr, 16'h0002);
        step(); check("inc_3", fetch_addr, 16'h0003);
        check("inc_ra_hold", ra_out, 16'h0000);
        inc0 = 1'b0;

        // Load PC then flip roles
        load_pc = 1'b1; load_data = 16'h1234;
        step(); check("load_pc", fetch_addr, 16'h1234);
        load_pc = 1'b0; flip = 1'b1;
        step(); flip = 1'b0;
        check("flip_fetch", fetch_addr, 16'h0000);
        check("flip_ra", ra_out, 16'h1234);
        check("flip_flag", {15'd0, flag_flip}, 16'h0001);

        // PC is now reg1: wrap it
        load_pc = 1'b1; load_data = 16'hFFFF;
        step(); load_pc = 1'b0;
        check("load_ffff", fetch_addr, 16'hFFFF);
        inc1 = 1'b1;
        step(); inc1 = 1'b0;
        check("wrap_addr", fetch_addr, 16'h0000);
        check("wrap_flag", {15'd0, pc_wrap}, {15'd0, exp_wrap});
        step();
        check("wrap_sticky", {15'd0, pc_wrap}, {15'd0, exp_wrap});

        // Load beats increment; load clears wrap
        load_pc = 1'b1; inc1 = 1'b1; load_data = 16'h5555;
        step(); load_pc = 1'b0; inc1 = 1'b0;
        check("load_over_inc", fetch_addr, 16'h5555);
        check("wrap_cleared", {15'd0, pc_wrap}, 16'h0000);

        // Flip and inc together: inc hits physical reg0, flip afterwards
        flip = 1'b1; inc0 = 1'b1;
        step(); flip = 1'b0; inc0 = 1'b0;
        check("flipinc_fetch", fetch_addr, 16'h1235);
        check("flipinc_ra", ra_out, 16'h5555);
        check("flipinc_flag", {15'd0, flag_flip}, 16'h0000);

        // Both loads together
        load_pc = 1'b1; load_ra = 1'b1; load_data = 16'h0100;
        step(); load_pc = 1'b0; load_ra = 1'b0;
        check("dual_load_pc", fetch_addr, 16'h0100);
        check("dual_load_ra", ra_out, 16'h0100);

        // Bus request held four cycles
        bus_req = 1'b1;
        step();
        check("drain_valid", {15'd0, fetch_valid}, 16'h0000);
        check("drain_grant", {15'd0, bus_grant}, 16'h0000);
        step();
        check("grant_grant", {15'd0, bus_grant}, 16'h0001);
        check("grant_valid", {15'd0, fetch_valid}, 16'h0000);
        inc0 = 1'b1;
        step();
        check("grant_inc_ignored", fetch_addr, 16'h0100);
        inc0 = 1'b0; load_ra = 1'b1; load_data = 16'h0ABC;
        step(); load_ra = 1'b0;
        check("grant_load_ra", ra_out, 16'h0ABC);
        check("grant_held", {15'd0, bus_grant}, 16'h0001);
        bus_req = 1'b0;
        step();
        check("release_valid", {15'd0, fetch_valid}, 16'h0001);
        check("release_grant", {15'd0, bus_grant}, 16'h0000);

        // One-cycle request pulse: no grant
        bus_req = 1'b1;
        step(); bus_req = 1'b0;
        check("pulse_drain_valid", {15'd0, fetch_valid}, 16'h0000);
        step();
        check("pulse_back_valid", {15'd0, fetch_valid}, 16'h0001);
        check("pulse_no_grant", {15'd0, bus_grant}, 16'h0000);
        inc0 = 1'b1;
        step(); inc0 = 1'b0;
        check("inc_after_bus", fetch_addr, 16'h0101);

        // Asynchronous reset while granted
        bus_req = 1'b1;
        step(); step();
        check("pre_reset_grant", {15'd0, bus_grant}, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_grant", {15'd0, bus_grant}, 16'h0000);
        check("async_rst_addr", fetch_addr, 16'h0000);
        check("async_rst_ra", ra_out, 16'h0000);
        check("async_rst_valid", {15'd0, fetch_valid}, 16'h0001);
        bus_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
